video_source_arbiter: RTL and testbench

Shares one video pipeline source, such as the generator-backed source, between two downstream pipeline consumers (ports A and B). It arbitrates chunk requests from the two consumers' request FIFOs round-robin and presents them to the source as a FIFO read interface. It records which consumer owns each accepted request, then steers every CHUNK_SIZE-pixel response burst from the source back to the owning consumer's response FIFO. It sits between the source's request/response FIFO ports and two consumers such as a scaler and a capture/filter branch.

---
 rtl/video_pipeline_pkg.sv | 26 ++
 rtl/video_tag_queue.sv | 54 +++++
 rtl/video_source_arbiter.sv | 147 ++++++++++++++
 tb/tb_video_source_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pipeline_pkg.sv
// Shared video pipeline constants, request geometry helpers and owner IDs.
package video_pipeline_pkg;

    localparam int HACTIVE_BITS   = 11;
    localparam int VACTIVE_BITS   = 11;
    localparam int BITS_PER_PIXEL = 16;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        FETCH = 3'b010,
        HOLD  = 3'b100
    } requestState_t;

    // Request geometry depends on the chunk size chosen by the instantiating block.
    function automatic int chunkNumBits(input int chunkBits);
        return HACTIVE_BITS - chunkBits;
    endfunction

    function automatic int requestBits(input int chunkBits);
        return VACTIVE_BITS + chunkNumBits(chunkBits);
    endfunction

endpackage

// File: rtl/video_tag_queue.sv
// Show-ahead 1-bit FIFO recording which consumer owns each outstanding chunk.
module video_tag_queue #(
    parameter int ADDR_WIDTH = 2
) (
    input  logic scalerClock,
    input  logic reset,
    input  logic push,
    input  logic pushData,
    input  logic pop,
    output logic headData,
    output logic empty,
    output logic full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0]      entries;
    logic [ADDR_WIDTH-1:0] writePtr;
    logic [ADDR_WIDTH-1:0] readPtr;
    logic [ADDR_WIDTH:0]   count;
    logic                  doPush;
    logic                  doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            entries  <= '0;
            writePtr <= '0;
            readPtr  <= '0;
            count    <= '0;
        end else begin
            if (doPush) begin
                entries[writePtr] <= pushData;
                writePtr          <= writePtr + 1'b1;
            end
            if (doPop) begin
                readPtr <= readPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Count never exceeds DEPTH, so its top bit alone marks the full condition.
    assign headData = entries[readPtr];
    assign empty    = (count == '0);
    assign full     = count[ADDR_WIDTH];

endmodule

// File: rtl/video_source_arbiter.sv
// Round-robin sharing of one video source between consumers A and B, with
// in-order steering of each response chunk back to the consumer that asked for it.
module video_source_arbiter
    import video_pipeline_pkg::*;
#(
    parameter int  CHUNK_BITS     = 5,
    parameter int  TAG_ADDR_WIDTH = 2,
    localparam int REQUEST_BITS   = requestBits(CHUNK_BITS)
) (
    input  logic                      scalerClock,
    input  logic                      reset,
    output logic                      reqAReadEnable,
    output logic                      reqBReadEnable,
    input  logic                      reqAEmpty,
    input  logic                      reqBEmpty,
    input  logic [REQUEST_BITS-1:0]   reqAReadData,
    input  logic [REQUEST_BITS-1:0]   reqBReadData,
    input  logic                      srcRequestReadEnable,
    output logic                      srcRequestEmpty,
    output logic [REQUEST_BITS-1:0]   srcRequestReadData,
    input  logic                      srcResponseWriteEnable,
    output logic                      srcResponseFull,
    input  logic [BITS_PER_PIXEL-1:0] srcResponseWriteData,
    output logic                      respAWriteEnable,
    output logic                      respBWriteEnable,
    input  logic                      respAFull,
    input  logic                      respBFull,
    output logic [BITS_PER_PIXEL-1:0] respWriteData,
    output logic                      overflowError
);

    localparam logic [CHUNK_BITS-1:0] CHUNK_LAST = '1;

    requestState_t             state;
    requestState_t             nextState;
    logic                      grantSelect;
    logic                      grantOwner;
    logic                      lastGrant;
    logic [REQUEST_BITS-1:0]   holdData;
    logic                      holdOwner;
    logic                      requestAccept;
    logic                      tagHead;
    logic                      tagEmpty;
    logic                      tagFull;
    logic                      tagPop;
    logic                      responseAccept;
    logic [CHUNK_BITS-1:0]     pixelCount;

    always_comb begin
        nextState       = state;
        grantSelect     = OWNER_A;
        reqAReadEnable  = 1'b0;
        reqBReadEnable  = 1'b0;
        srcRequestEmpty = 1'b1;
        requestAccept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reqAEmpty || !reqBEmpty) begin
                    if (reqAEmpty) begin
                        grantSelect = OWNER_B;
                    end else if (reqBEmpty) begin
                        grantSelect = OWNER_A;
                    end else begin
                        grantSelect = ~lastGrant;
                    end
                    reqAReadEnable = (grantSelect == OWNER_A);
                    reqBReadEnable = (grantSelect == OWNER_B);
                    nextState      = FETCH;
                end
            end
            FETCH: begin
                nextState = HOLD;
            end
            HOLD: begin
                // Holding the request back while the tag queue is full caps outstanding chunks.
                srcRequestEmpty = tagFull;
                if (srcRequestReadEnable && !tagFull) begin
                    requestAccept = 1'b1;
                    nextState     = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            grantOwner         <= OWNER_A;
            lastGrant          <= OWNER_B;
            holdData           <= '0;
            holdOwner          <= OWNER_A;
            srcRequestReadData <= '0;
        end else begin
            state <= nextState;
            if (reqAReadEnable || reqBReadEnable) begin
                grantOwner <= grantSelect;
            end
            if (state == FETCH) begin
                holdData  <= (grantOwner == OWNER_A) ? reqAReadData : reqBReadData;
                holdOwner <= grantOwner;
            end
            if (requestAccept) begin
                srcRequestReadData <= holdData;
                lastGrant          <= holdOwner;
            end
        end
    end

    video_tag_queue #(
        .ADDR_WIDTH(TAG_ADDR_WIDTH)
    ) tagQueue (
        .scalerClock(scalerClock),
        .reset      (reset),
        .push       (requestAccept),
        .pushData   (holdOwner),
        .pop        (tagPop),
        .headData   (tagHead),
        .empty      (tagEmpty),
        .full       (tagFull)
    );

    // Responses are strictly in order: only the head tag's consumer may receive pixels.
    assign srcResponseFull  = tagEmpty || ((tagHead == OWNER_A) ? respAFull : respBFull);
    assign responseAccept   = srcResponseWriteEnable && !srcResponseFull;
    assign respAWriteEnable = responseAccept && (tagHead == OWNER_A);
    assign respBWriteEnable = responseAccept && (tagHead == OWNER_B);
    assign respWriteData    = srcResponseWriteData;
    assign tagPop           = responseAccept && (pixelCount == CHUNK_LAST);

    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            pixelCount    <= '0;
            overflowError <= 1'b0;
        end else begin
            if (responseAccept) begin
                pixelCount <= pixelCount + 1'b1;
            end
            if (srcResponseWriteEnable && srcResponseFull) begin
                overflowError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_source_arbiter.sv
// Randomized bench for video_source_arbiter against a chunk-level model of
// round-robin ordering, in-order response ownership and the outstanding-chunk limit.
module tb_video_source_arbiter;
    import video_pipeline_pkg::*;

    localparam int CHUNK_BITS = 5;
    localparam int CHUNK_SIZE = 1 << CHUNK_BITS;
    localparam int TAG_DEPTH  = 4;
    localparam int REQ_BITS   = requestBits(CHUNK_BITS);

    typedef struct packed {
        logic                owner;
        logic [REQ_BITS-1:0] data;
    } expReq_t;

    logic                      scalerClock;
    logic                      reset;
    logic                      reqAReadEnable;
    logic                      reqBReadEnable;
    logic                      reqAEmpty;
    logic                      reqBEmpty;
    logic [REQ_BITS-1:0]       reqAReadData;
    logic [REQ_BITS-1:0]       reqBReadData;
    logic                      srcRequestReadEnable;
    logic                      srcRequestEmpty;
    logic [REQ_BITS-1:0]       srcRequestReadData;
    logic                      srcResponseWriteEnable;
    logic                      srcResponseFull;
    logic [BITS_PER_PIXEL-1:0] srcResponseWriteData;
    logic                      respAWriteEnable;
    logic                      respBWriteEnable;
    logic                      respAFull;
    logic                      respBFull;
    logic [BITS_PER_PIXEL-1:0] respWriteData;
    logic                      overflowError;

    video_source_arbiter #(
        .CHUNK_BITS    (CHUNK_BITS),
        .TAG_ADDR_WIDTH(2)
    ) dut (
        .scalerClock           (scalerClock),
        .reset                 (reset),
        .reqAReadEnable        (reqAReadEnable),
        .reqBReadEnable        (reqBReadEnable),
        .reqAEmpty             (reqAEmpty),
        .reqBEmpty             (reqBEmpty),
        .reqAReadData          (reqAReadData),
        .reqBReadData          (reqBReadData),
        .srcRequestReadEnable  (srcRequestReadEnable),
        .srcRequestEmpty       (srcRequestEmpty),
        .srcRequestReadData    (srcRequestReadData),
        .srcResponseWriteEnable(srcResponseWriteEnable),
        .srcResponseFull       (srcResponseFull),
        .srcResponseWriteData  (srcResponseWriteData),
        .respAWriteEnable      (respAWriteEnable),
        .respBWriteEnable      (respBWriteEnable),
        .respAFull             (respAFull),
        .respBFull             (respBFull),
        .respWriteData         (respWriteData),
        .overflowError         (overflowError)
    );

    initial scalerClock = 1'b0;
    always #5 scalerClock = ~scalerClock;

    int checks = 0;
    int passes = 0;

    logic [REQ_BITS-1:0]       qA[$];
    logic [REQ_BITS-1:0]       qB[$];
    expReq_t                   expReq[$];
    logic                      grantQ[$];
    logic                      ownQ[$];
    logic [BITS_PER_PIXEL-1:0] expA[$];
    logic [BITS_PER_PIXEL-1:0] expB[$];
    logic [BITS_PER_PIXEL-1:0] gotA[$];
    logic [BITS_PER_PIXEL-1:0] gotB[$];
    int                        pixCnt;
    int                        srcOwed;
    logic                      ovfModel;
    logic                      lastGrantModel;
    int                        readRate;
    int                        writeRate;
    int                        fullRate;
    bit                        forceWrite;
    bit                        seqPixels;
    logic [BITS_PER_PIXEL-1:0] pixelSeq;
    bit                        bpArm;
    int                        bpCycles;
    bit                        pendingReadCheck;
    logic [REQ_BITS-1:0]       pendingReadData;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) passes = passes + 1;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic checkResetValues();
        checkOutput("resetReqAReadEnable", 32'(reqAReadEnable), 32'd0);
        checkOutput("resetReqBReadEnable", 32'(reqBReadEnable), 32'd0);
        checkOutput("resetRespAWriteEnable", 32'(respAWriteEnable), 32'd0);
        checkOutput("resetRespBWriteEnable", 32'(respBWriteEnable), 32'd0);
        checkOutput("resetOverflowError", 32'(overflowError), 32'd0);
        checkOutput("resetSrcRequestEmpty", 32'(srcRequestEmpty), 32'd1);
        checkOutput("resetSrcResponseFull", 32'(srcResponseFull), 32'd1);
        checkOutput("resetSrcRequestReadData", 32'(srcRequestReadData), 32'd0);
    endtask

    // Consumer and source FIFOs are reset together with the arbiter.
    task automatic resetDut();
        srcRequestReadEnable   = 1'b0;
        srcResponseWriteEnable = 1'b0;
        respAFull              = 1'b0;
        respBFull              = 1'b0;
        qA.delete();
        qB.delete();
        reqAEmpty = 1'b1;
        reqBEmpty = 1'b1;
        reset     = 1'b1;
        #1;
        checkResetValues();
        @(negedge scalerClock);
        reset = 1'b0;
        expReq.delete();
        grantQ.delete();
        ownQ.delete();
        expA.delete();
        expB.delete();
        gotA.delete();
        gotB.delete();
        pixCnt           = 0;
        srcOwed          = 0;
        ovfModel         = 1'b0;
        lastGrantModel   = OWNER_B;
        pendingReadCheck = 1'b0;
        bpCycles         = 0;
        bpArm            = 1'b0;
        pixelSeq         = '0;
    endtask

    // Loads both consumer FIFOs at once and derives the source-visible order
    // from the round-robin rule applied to the remaining request counts.
    task automatic loadRequests(input int nA, input int nB, input logic [REQ_BITS-1:0] firstA);
        logic [REQ_BITS-1:0] newA[$];
        logic [REQ_BITS-1:0] newB[$];
        int                  ia;
        int                  ib;
        logic                pick;
        expReq_t             e;
        ia = 0;
        ib = 0;
        for (int i = 0; i < nA; i++) newA.push_back((i == 0) ? firstA : REQ_BITS'($urandom));
        for (int i = 0; i < nB; i++) newB.push_back(REQ_BITS'($urandom));
        while (ia < nA || ib < nB) begin
            if (ia >= nA) pick = OWNER_B;
            else if (ib >= nB) pick = OWNER_A;
            else pick = (lastGrantModel == OWNER_A) ? OWNER_B : OWNER_A;
            e.owner = pick;
            if (pick == OWNER_A) begin
                e.data = newA[ia];
                ia++;
            end else begin
                e.data = newB[ib];
                ib++;
            end
            expReq.push_back(e);
            grantQ.push_back(pick);
            lastGrantModel = pick;
        end
        foreach (newA[i]) qA.push_back(newA[i]);
        foreach (newB[i]) qB.push_back(newB[i]);
        reqAEmpty = (qA.size() == 0);
        reqBEmpty = (qB.size() == 0);
    endtask

    // One clock cycle: drive at the falling edge, sample just before the rising edge.
    task automatic applyStimulus();
        logic    expFull;
        logic    expHead;
        logic    steer;
        logic    popA;
        logic    popB;
        logic    srcPop;
        expReq_t e;
        if (bpCycles == 0 && bpArm && ownQ.size() > 0 && ownQ[0] == OWNER_B && pixCnt >= 8) begin
            bpCycles = 10;
            bpArm    = 1'b0;
        end
        respAFull = (fullRate > 0) && ($urandom_range(99) < fullRate);
        respBFull = (bpCycles > 0) || ((fullRate > 0) && ($urandom_range(99) < fullRate));
        if (bpCycles > 0) bpCycles--;
        srcRequestReadEnable = ($urandom_range(99) < readRate);
        #1;
        srcResponseWriteEnable = forceWrite ||
                                 (srcOwed > 0 && !srcResponseFull && ($urandom_range(99) < writeRate));
        srcResponseWriteData = seqPixels ? pixelSeq : BITS_PER_PIXEL'($urandom);
        #2;
        expHead = (ownQ.size() > 0) ? ownQ[0] : OWNER_A;
        expFull = (ownQ.size() == 0) || ((expHead == OWNER_A) ? respAFull : respBFull);
        steer   = srcResponseWriteEnable && !expFull;
        checkOutput("srcResponseFull", 32'(srcResponseFull), 32'(expFull));
        checkOutput("respAWriteEnable", 32'(respAWriteEnable), 32'(steer && expHead == OWNER_A));
        checkOutput("respBWriteEnable", 32'(respBWriteEnable), 32'(steer && expHead == OWNER_B));
        checkOutput("overflowError", 32'(overflowError), 32'(ovfModel));
        if (ownQ.size() == TAG_DEPTH) checkOutput("srcRequestEmptyAtLimit", 32'(srcRequestEmpty), 32'd1);
        if (respAWriteEnable) gotA.push_back(respWriteData);
        if (respBWriteEnable) gotB.push_back(respWriteData);
        popA = reqAReadEnable;
        popB = reqBReadEnable;
        if (popA || popB) begin
            if (grantQ.size() == 0) begin
                checkOutput("unexpectedGrant", 32'({popA, popB}), 32'd0);
            end else begin
                checkOutput("grantOwner", 32'({popA, popB}), (grantQ[0] == OWNER_A) ? 32'd2 : 32'd1);
                void'(grantQ.pop_front());
            end
        end
        if (srcResponseWriteEnable && expFull) ovfModel = 1'b1;
        if (steer) begin
            if (expHead == OWNER_A) expA.push_back(srcResponseWriteData);
            else expB.push_back(srcResponseWriteData);
            srcOwed--;
            pixelSeq++;
            pixCnt++;
            if (pixCnt == CHUNK_SIZE) begin
                void'(ownQ.pop_front());
                pixCnt = 0;
            end
        end
        srcPop = srcRequestReadEnable && !srcRequestEmpty;
        if (srcPop) begin
            if (expReq.size() == 0) begin
                checkOutput("unexpectedSrcRequest", 32'(srcRequestEmpty), 32'd1);
            end else begin
                e                = expReq.pop_front();
                pendingReadCheck = 1'b1;
                pendingReadData  = e.data;
                ownQ.push_back(e.owner);
                srcOwed += CHUNK_SIZE;
            end
        end
        @(negedge scalerClock);
        if (popA && qA.size() > 0) reqAReadData = qA.pop_front();
        if (popB && qB.size() > 0) reqBReadData = qB.pop_front();
        reqAEmpty = (qA.size() == 0);
        reqBEmpty = (qB.size() == 0);
        if (pendingReadCheck) begin
            checkOutput("srcRequestReadData", 32'(srcRequestReadData), 32'(pendingReadData));
            pendingReadCheck = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((expReq.size() > 0 || ownQ.size() > 0 || qA.size() > 0 || qB.size() > 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(ownQ.size() + expReq.size()), 32'd0);
    endtask

    task automatic compareStreams(input string tag);
        checkOutput({tag, "CountA"}, 32'(gotA.size()), 32'(expA.size()));
        checkOutput({tag, "CountB"}, 32'(gotB.size()), 32'(expB.size()));
        for (int i = 0; i < expA.size() && i < gotA.size(); i++)
            checkOutput({tag, "PixelA"}, 32'(gotA[i]), 32'(expA[i]));
        for (int i = 0; i < expB.size() && i < gotB.size(); i++)
            checkOutput({tag, "PixelB"}, 32'(gotB[i]), 32'(expB[i]));
        expA.delete();
        expB.delete();
        gotA.delete();
        gotB.delete();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset                  = 1'b0;
        reqAEmpty              = 1'b1;
        reqBEmpty              = 1'b1;
        reqAReadData           = '0;
        reqBReadData           = '0;
        srcRequestReadEnable   = 1'b0;
        srcResponseWriteEnable = 1'b0;
        srcResponseWriteData   = '0;
        respAFull              = 1'b0;
        respBFull              = 1'b0;
        readRate               = 0;
        writeRate              = 0;
        fullRate               = 0;
        forceWrite             = 1'b0;
        seqPixels              = 1'b0;
        @(negedge scalerClock);
        resetDut();

        $display("[TB] single request");
        seqPixels = 1'b1;
        loadRequests(1, 0, REQ_BITS'(17'h1234));
        applyStimulus();
        checkOutput("latencyCycle1", 32'(srcRequestEmpty), 32'd1);
        applyStimulus();
        checkOutput("latencyCycle2", 32'(srcRequestEmpty), 32'd0);
        readRate  = 100;
        writeRate = 100;
        drain("singleDrain", 200);
        checkOutput("singleCountA", 32'(gotA.size()), 32'd32);
        checkOutput("singleCountB", 32'(gotB.size()), 32'd0);
        for (int i = 0; i < gotA.size() && i < 32; i++)
            checkOutput("singlePixelOrder", 32'(gotA[i]), 32'(i));
        compareStreams("single");
        seqPixels = 1'b0;

        $display("[TB] contention");
        resetDut();
        readRate  = 100;
        writeRate = 100;
        loadRequests(3, 3, REQ_BITS'($urandom));
        drain("contentionDrain", 800);
        compareStreams("contention");

        $display("[TB] back-pressure");
        bpArm = 1'b1;
        loadRequests(1, 2, REQ_BITS'($urandom));
        drain("backPressureDrain", 600);
        checkOutput("backPressureApplied", 32'(bpArm), 32'd0);
        compareStreams("backPressure");

        $display("[TB] outstanding limit");
        writeRate = 0;
        loadRequests(4, 2, REQ_BITS'($urandom));
        n = 0;
        while (ownQ.size() < TAG_DEPTH && n < 100) begin
            applyStimulus();
            n++;
        end
        checkOutput("limitReached", 32'(ownQ.size()), 32'(TAG_DEPTH));
        repeat (15) applyStimulus();
        checkOutput("limitHold", 32'(srcRequestEmpty), 32'd1);
        writeRate = 100;
        n = 0;
        while (ownQ.size() == TAG_DEPTH && n < 100) begin
            applyStimulus();
            n++;
        end
        checkOutput("limitRelease", 32'(srcRequestEmpty), 32'd0);
        drain("limitDrain", 800);
        compareStreams("limit");

        $display("[TB] overflow");
        readRate   = 0;
        writeRate  = 0;
        forceWrite = 1'b1;
        applyStimulus();
        forceWrite = 1'b0;
        applyStimulus();
        checkOutput("overflowSticky", 32'(overflowError), 32'd1);
        checkOutput("overflowNoWrite", 32'(gotA.size() + gotB.size()), 32'd0);

        $display("[TB] mid-burst reset");
        readRate  = 100;
        writeRate = 100;
        loadRequests(2, 2, REQ_BITS'($urandom));
        n = 0;
        while (!(ownQ.size() > 0 && pixCnt >= 10) && n < 200) begin
            applyStimulus();
            n++;
        end
        checkOutput("midBurstReached", 32'(pixCnt >= 10), 32'd1);
        resetDut();
        loadRequests(1, 1, REQ_BITS'($urandom));
        drain("afterResetDrain", 400);
        compareStreams("afterReset");

        $display("[TB] random traffic");
        for (int r = 0; r < 6; r++) begin
            readRate  = int'($urandom_range(100, 40));
            writeRate = int'($urandom_range(100, 40));
            fullRate  = int'($urandom_range(30, 0));
            loadRequests(int'($urandom_range(4, 0)), int'($urandom_range(4, 1)), REQ_BITS'($urandom));
            drain("randomDrain", 4000);
            compareStreams("random");
        end
        fullRate = 0;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
